output_control: RTL
===================

// Module: output_control
// PURPOSE
// - Return path of the tiny TPU: captures the N*N result matrix from the systolic array in one cycle,
//   then streams it off-chip bit-serially on one pin, LSB-first, the mirror of the serial input loader.
// - Sits between the array's result bus and the chip's serial output pin; host paces it with read_en.
// PARAMETERS
// - D_W   8    operand width; result word width OUT_W = 2*D_W (localparam)
// - N     2    array dimension; N*N result words buffered
// PORTS
// - clk       in   1            single clock, rising edge
// - rst_n     in   1            asynchronous, active-low reset
// - in_z_flat in   N*N*OUT_W    result words; word k=r*N+c at bits [(k+1)*OUT_W-1 -: OUT_W]
// - capture   in   1            1-cycle pulse: in_z_flat valid this cycle
// - read_en   in   1            host strobe: one serial bit per cycle while high
// - data_out  out  1            serial result bit (registered)
// - out_valid out  1            data_out carries a valid bit this cycle
// - busy      out  1            buffer holds unsent data (state SHIFT)
// - done      out  1            1-cycle pulse after the final bit
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; buffer, counters, data_out, out_valid, busy, done = 0.
// - States: IDLE -> SHIFT on capture; SHIFT -> DONE after final bit sent; DONE -> IDLE unconditionally.
// - IDLE: capture=1 latches all N*N words into buffer on that edge, word_cnt=0, bit_cnt=0, -> SHIFT.
// - SHIFT, read_en=1: data_out <= buffer[word_cnt][bit_cnt], out_valid <= 1, bit_cnt++;
//   bit_cnt wraps OUT_W-1 -> 0 with word_cnt++. Latency: bit appears the cycle after its read_en cycle.
// - SHIFT, read_en=0: out_valid <= 0, data_out holds, counters hold (pause without loss).
// - Order: word 0..N*N-1 row-major, each word bit 0 first; total N*N*OUT_W valid bits.
// - Last bit (word N*N-1, bit OUT_W-1) sent -> DONE; done=1 for exactly the DONE cycle; busy=0 in DONE.
// - capture while SHIFT or DONE: ignored, buffer unchanged. read_en in IDLE/DONE: out_valid=0.
// - capture and read_en in same IDLE cycle: capture wins, no bit sent that cycle.
// - rst_n mid-transfer: immediate abort, all outputs 0, partial data discarded.
// - Counters: word_cnt $clog2(N*N) bits (min 1), bit_cnt $clog2(OUT_W) bits; no arithmetic overflow.
// CONFIGURATION
// - OUTPUT_CONTROL_PARITY_EN defined: after bit OUT_W-1 of each word, one extra serial bit = even
//   parity (XOR of the word's OUT_W bits) with out_valid=1; word frame is OUT_W+1 bits,
//   total N*N*(OUT_W+1).
// - Undefined: words back-to-back, no parity bit, total N*N*OUT_W bits.
// STRUCTURE
// - Shared package tpu_pkg: state encodings (IDLE/SHIFT/DONE), OUT_W derivation, flat-bus slice helper.
// - One sub-module: piso_word (OUT_W-bit parallel-in serial-out shift register with load/shift/hold,
//   and the parity tap when the macro is set); output_control owns FSM, buffer and word sequencing.
// TESTING (N=2, D_W=8, OUT_W=16)
// - Reset: rst_n low mid-SHIFT -> same cycle data_out=0, out_valid=0, busy=0; next capture restarts at word 0.
// - Full stream: capture words {0x0001,0x8000,0x00FF,0xA5A5}, read_en held high -> 64 valid bits:
//   1,0x15 | 0x15,1 | 1x8,0x8 | 1,0,1,0,0,1,0,1 twice; done pulses once, cycle after bit 63.
// - Pause: drop read_en for 5 cycles after bit 20 -> out_valid=0 for 5 cycles, bit 21 resumes correctly.
// - Overlap: capture 0xFFFF x4 during SHIFT -> ignored, stream still equals first captured data.
// - Idle read: read_en high in IDLE for 10 cycles -> out_valid stays 0, busy 0, done 0.
// - Parity (macro set): same data as Full stream -> 68 bits; parity bits 1,1,0,0 after each word.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: FSM state encodings, result-width derivation and flat-bus slicing helper.
package tpu_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    function automatic int out_width(input int d_w);
        return 2 * d_w;
    endfunction

    // Word k of a flat result bus starts at this bit offset.
    function automatic int word_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/output_control_piso_word.sv
// Parallel-in serial-out register for one result word, LSB leaves first.
// With OUTPUT_CONTROL_PARITY_EN defined it also holds the even parity of the loaded word.
module piso_word #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         bit_out
`ifdef OUTPUT_CONTROL_PARITY_EN
    ,
    output logic         parity
`endif
);

    logic [W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {1'b0, sr[W-1:1]};
        end
    end

    assign bit_out = sr[0];

`ifdef OUTPUT_CONTROL_PARITY_EN
    // Parity is taken from the loaded value, so it survives the word being shifted out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity <= 1'b0;
        end else if (load) begin
            parity <= ^din;
        end
    end
`endif

endmodule

// File: rtl/output_control.sv
// Result return path: captures the N*N result matrix in one cycle and streams it LSB-first on one pin.
// Define OUTPUT_CONTROL_PARITY_EN to append an even-parity bit after every word.
module output_control
    import tpu_pkg::*;
#(
    parameter int D_W = 8,
    parameter int N   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N*N*out_width(D_W)-1:0]     in_z_flat,
    input  logic                              capture,
    input  logic                              read_en,
    output logic                              data_out,
    output logic                              out_valid,
    output logic                              busy,
    output logic                              done
);

    localparam int OUT_W = out_width(D_W);
    localparam int WORDS = N * N;
`ifdef OUTPUT_CONTROL_PARITY_EN
    localparam int FRAME_W = OUT_W + 1;
`else
    localparam int FRAME_W = OUT_W;
`endif
    localparam int WC_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BC_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(FRAME_W - 1);

    state_t           state;
    logic [OUT_W-1:0] buffer [WORDS];
    logic [WC_W-1:0]  word_cnt;
    logic [BC_W-1:0]  bit_cnt;

    logic             send;
    logic             frame_end;
    logic             last_bit;
    logic             serial_bit;
    logic             piso_load;
    logic             piso_bit;
    logic [OUT_W-1:0] piso_din;
    logic [WC_W-1:0]  next_word;

    assign send      = (state == ST_SHIFT) && read_en;
    assign frame_end = (bit_cnt == LAST_BIT);
    assign last_bit  = frame_end && (word_cnt == LAST_WORD);
    assign next_word = word_cnt + 1'b1;

    // Word 0 goes straight into the shifter on capture; later words come from the buffer at frame end.
    assign piso_load = ((state == ST_IDLE) && capture) || (send && frame_end && !last_bit);

    always_comb begin
        piso_din = in_z_flat[word_lsb(0, OUT_W) +: OUT_W];
        if (state != ST_IDLE) begin
            piso_din = buffer[next_word];
        end
    end

`ifdef OUTPUT_CONTROL_PARITY_EN
    logic piso_parity;

    assign serial_bit = (bit_cnt == BC_W'(OUT_W)) ? piso_parity : piso_bit;

    piso_word #(.W(OUT_W)) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (piso_load),
        .shift   (send),
        .din     (piso_din),
        .bit_out (piso_bit),
        .parity  (piso_parity)
    );
`else
    assign serial_bit = piso_bit;

    piso_word #(.W(OUT_W)) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (piso_load),
        .shift   (send),
        .din     (piso_din),
        .bit_out (piso_bit)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            bit_cnt   <= '0;
            data_out  <= 1'b0;
            out_valid <= 1'b0;
            for (int k = 0; k < WORDS; k++) begin
                buffer[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        for (int k = 0; k < WORDS; k++) begin
                            buffer[k] <= in_z_flat[word_lsb(k, OUT_W) +: OUT_W];
                        end
                        word_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (read_en) begin
                        data_out  <= serial_bit;
                        out_valid <= 1'b1;
                        if (frame_end) begin
                            bit_cnt <= '0;
                            if (last_bit) begin
                                state <= ST_DONE;
                            end else begin
                                word_cnt <= next_word;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule
